// File: rtl/rr_timeslice_arbiter_pkg.sv
// Shared types and helpers for the time-sliced round-robin arbiter.
package rr_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // A one-requester arbiter still needs a one-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_timeslice_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_timeslice_arbiter_if
    import rr_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int SLICE = 4
);
    localparam int IW = idx_width(N);
    localparam int CW = $clog2(SLICE + 1);

    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;
    logic [CW-1:0] slice_cnt;

    modport master (
        output req,
        input  gnt, gnt_valid, gnt_id, slice_cnt
    );

    modport slave (
        input  req,
        output gnt, gnt_valid, gnt_id, slice_cnt
    );

endinterface

// File: rtl/rr_timeslice_arbiter_pick.sv
// Combinational rotate-priority encoder: first active request at or after start,
// wrapping at N-1, optionally skipping one index.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  logic          excl_en,
    input  logic [IW-1:0] excl_idx,
    output logic          found,
    output logic [IW-1:0] idx
);

    int unsigned   pos;
    logic [IW-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos  = (32'(start) + k) % N;
            cand = IW'(pos);
            if (!found && req[cand] && !(excl_en && cand == excl_idx)) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_timeslice_arbiter.sv
// Round-robin arbiter with a bounded time slice per grant; all outputs registered.
module rr_timeslice_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int SLICE = 4
) (
    input  logic clk,
    input  logic rst_n,
    rr_timeslice_arbiter_if.slave bus
);

    localparam int IW = idx_width(N);
    localparam int CW = $clog2(SLICE + 1);

    state_t        state, state_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [IW-1:0] id, id_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [N-1:0]  gnt, gnt_n;
    logic          valid;
    logic [IW-1:0] start, win, sel;
    logic          found, excl_en, grant;

    // Search always begins after the most recent grant; in GRANT that is the holder.
    assign start   = (ptr == IW'(N - 1)) ? '0 : ptr + 1'b1;
    assign excl_en = (state == ST_GRANT);

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req      (bus.req),
        .start    (start),
        .excl_en  (excl_en),
        .excl_idx (id),
        .found    (found),
        .idx      (win)
    );

    // On expiry with no other requester the holder is re-granted a fresh slice.
    assign sel = found ? win : id;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        id_n    = id;
        cnt_n   = cnt;
        grant   = 1'b0;
        case (state)
            ST_IDLE: begin
                grant = found;
            end
            ST_GRANT: begin
                if (!bus.req[id]) begin
                    if (found) begin
                        grant = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end
                end else if (cnt < CW'(SLICE)) begin
                    cnt_n = cnt + 1'b1;
                end else begin
                    grant = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (grant) begin
            state_n = ST_GRANT;
            ptr_n   = sel;
            id_n    = sel;
            cnt_n   = CW'(1);
        end
        gnt_n = '0;
        if (state_n == ST_GRANT) begin
            gnt_n[id_n] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr   <= IW'(N - 1);
            id    <= '0;
            cnt   <= '0;
            gnt   <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            id    <= id_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
            valid <= (state_n == ST_GRANT);
        end
    end

    assign bus.gnt       = gnt;
    assign bus.gnt_valid = valid;
    assign bus.gnt_id    = id;
    assign bus.slice_cnt = cnt;

endmodule

// File: tb/tb_rr_timeslice_arbiter.sv
// Checks SLICE=4 and SLICE=1 arbiters against a rule-level reference model.
module tb_rr_timeslice_arbiter;
    import rr_arb_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rr_timeslice_arbiter_if #(.N(N), .SLICE(4)) bus4 ();
    rr_timeslice_arbiter_if #(.N(N), .SLICE(1)) bus1 ();

    rr_timeslice_arbiter #(.N(N), .SLICE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    rr_timeslice_arbiter #(.N(N), .SLICE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state per instance: holder, cycles held (0 = idle), last granted index.
    int m_id [2];
    int m_cnt[2];
    int m_ptr[2];
    int slc  [2] = '{4, 1};

    function automatic int search(input logic [N-1:0] r, input int from, input int excl);
        for (int k = 1; k <= N; k++) begin
            int c = (from + k) % N;
            if ((((int'(r)) >> c) & 1) == 1 && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic give(input int d, input int w);
        m_id[d]  = w;
        m_ptr[d] = w;
        m_cnt[d] = 1;
    endtask

    task automatic model(input int d, input logic [N-1:0] r, input logic rs);
        int w;
        if (!rs) begin
            m_id[d]  = 0;
            m_cnt[d] = 0;
            m_ptr[d] = N - 1;
            return;
        end
        if (m_cnt[d] == 0) begin
            w = search(r, m_ptr[d], -1);
            if (w >= 0) give(d, w);
        end else if ((((int'(r)) >> m_id[d]) & 1) == 0) begin
            w = search(r, m_id[d], -1);
            if (w >= 0) give(d, w);
            else m_cnt[d] = 0;
        end else if (m_cnt[d] < slc[d]) begin
            m_cnt[d] = m_cnt[d] + 1;
        end else begin
            w = search(r, m_id[d], m_id[d]);
            give(d, (w >= 0) ? w : m_id[d]);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        int eg0, eg1;
        eg0 = (m_cnt[0] != 0) ? (1 << m_id[0]) : 0;
        eg1 = (m_cnt[1] != 0) ? (1 << m_id[1]) : 0;
        chk("s4.gnt",       32'(bus4.gnt),       32'(eg0));
        chk("s4.gnt_valid", 32'(bus4.gnt_valid), 32'(m_cnt[0] != 0));
        chk("s4.gnt_id",    32'(bus4.gnt_id),    32'(m_id[0]));
        chk("s4.slice_cnt", 32'(bus4.slice_cnt), 32'(m_cnt[0]));
        chk("s1.gnt",       32'(bus1.gnt),       32'(eg1));
        chk("s1.gnt_valid", 32'(bus1.gnt_valid), 32'(m_cnt[1] != 0));
        chk("s1.gnt_id",    32'(bus1.gnt_id),    32'(m_id[1]));
        chk("s1.slice_cnt", 32'(bus1.slice_cnt), 32'(m_cnt[1]));
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic rs);
        bus4.req = r;
        bus1.req = r;
        rst_n    = rs;
        @(posedge clk);
        model(0, r, rs);
        model(1, r, rs);
        #1;
        chk_all();
    endtask

    initial begin
        logic [N-1:0] r;
        logic         rs;
        bus4.req = '0;
        bus1.req = '0;

        // Reset, then idle with no requests
        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b0);
        repeat (5) cyc(4'b0000, 1'b1);

        // All requesting: four-cycle slices in order 0,1,2,3; SLICE=1 rotates every cycle
        for (int c = 0; c < 20; c++) begin
            cyc(4'b1111, 1'b1);
            chk("t2.s4_id",  32'(bus4.gnt_id),    32'((c / 4) % 4));
            chk("t2.s4_cnt", 32'(bus4.slice_cnt), 32'(c % 4 + 1));
            chk("t2.s1_id",  32'(bus1.gnt_id),    32'(c % 4));
        end

        // Lone requester re-granted with a fresh slice and no gap
        cyc(4'b0000, 1'b0);
        for (int c = 0; c < 10; c++) begin
            cyc(4'b0100, 1'b1);
            chk("t3.gnt", 32'(bus4.gnt),       32'h4);
            chk("t3.cnt", 32'(bus4.slice_cnt), 32'(c % 4 + 1));
        end

        // Early release hands over without a bubble, then goes idle keeping gnt_id
        cyc(4'b0000, 1'b0);
        cyc(4'b1011, 1'b1);
        cyc(4'b1011, 1'b1);
        chk("t4.cnt2", 32'(bus4.slice_cnt), 32'd2);
        cyc(4'b1010, 1'b1);
        chk("t4.handoff_gnt", 32'(bus4.gnt),       32'h2);
        chk("t4.handoff_cnt", 32'(bus4.slice_cnt), 32'd1);
        cyc(4'b0000, 1'b1);
        chk("t4.idle_valid", 32'(bus4.gnt_valid), 32'd0);
        chk("t4.idle_id",    32'(bus4.gnt_id),    32'd1);

        // Wrap-around from requester 3 back to 0, then expiry back to 3
        cyc(4'b0000, 1'b0);
        cyc(4'b1000, 1'b1);
        cyc(4'b0001, 1'b1);
        chk("t5.wrap_gnt", 32'(bus4.gnt), 32'h1);
        repeat (3) cyc(4'b1001, 1'b1);
        cyc(4'b1001, 1'b1);
        chk("t5.expiry_gnt", 32'(bus4.gnt), 32'h8);

        // Reset mid-grant clears outputs and restores requester 0 priority
        cyc(4'b0000, 1'b0);
        repeat (3) cyc(4'b0100, 1'b1);
        chk("t6.cnt3", 32'(bus4.slice_cnt), 32'd3);
        cyc(4'b0100, 1'b0);
        chk("t6.rst_gnt", 32'(bus4.gnt), 32'h0);
        cyc(4'b1111, 1'b1);
        chk("t6.first_gnt", 32'(bus4.gnt), 32'h1);

        // Random request traffic with occasional reset
        r = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 15));
            rs = ($urandom_range(0, 49) != 0);
            cyc(r, rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
